// File: rtl/input_conditioner.sv
// Button/switch front end for the game: synchronizers, per-button debounce, jump/restart strobes,
// IDLE/RUN/DEAD game FSM and registered speed/difficulty decode. Optional macro: JUMP_REPEAT_EN.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic       CLK100MHZ,
  input  logic       reset_n,
  input  logic       jump_btn,
  input  logic       restart_btn,
  input  logic       isdead,
  input  logic [3:0] speed_in,
  input  logic [3:0] difficulty_in,
  output logic       jump,
  output logic       jump_pulse,
  output logic       start,
  output logic       restart_pulse,
  output logic [2:0] speed,
  output logic [1:0] difficulty
);
  localparam int NUM_BTN = 2;
  localparam int BJ      = 0;
  localparam int BR      = 1;
  localparam int DW      = $clog2(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DEAD = 2'd2} state_t;
  state_t state, state_nx;

  // {difficulty[3:0], speed[3:0], restart, jump}
  logic [9:0] raw, meta, sync;
  assign raw = {difficulty_in, speed_in, restart_btn, jump_btn};

  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

  logic [NUM_BTN-1:0] btn_lvl, btn_lvl_q, btn_rise;

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_db
    logic [DW-1:0] cnt;
    logic          lvl;
    // Counter only runs while the synchronized input disagrees with the debounced level.
    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
      if (!reset_n) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (sync[b] == lvl) begin
        cnt <= '0;
      end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        cnt <= '0;
        lvl <= ~lvl;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
    assign btn_lvl[b] = lvl;
  end

  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) btn_lvl_q <= '0;
    else          btn_lvl_q <= btn_lvl;
  end

  assign btn_rise = btn_lvl & ~btn_lvl_q;

  logic rpt_hit;
`ifdef JUMP_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);
  logic [RW-1:0] rpt_cnt;
  assign rpt_hit = (state == RUN) && btn_lvl[BJ] && (rpt_cnt == RW'(REPEAT_CYCLES - 1));

  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n)
      rpt_cnt <= '0;
    else if ((state != RUN) || !btn_lvl[BJ] || btn_rise[BJ] || rpt_hit)
      rpt_cnt <= '0;
    else
      rpt_cnt <= rpt_cnt + 1'b1;
  end
`else
  logic unused_rpt;
  assign rpt_hit    = 1'b0;
  assign unused_rpt = ^REPEAT_CYCLES;
`endif

  assign jump          = btn_lvl[BJ];
  assign jump_pulse    = (btn_rise[BJ] && (state != DEAD)) || rpt_hit;
  assign restart_pulse = btn_rise[BR];

  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Restart wins over both isdead and jump.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!restart_pulse && jump_pulse) state_nx = RUN;
      RUN:     if (restart_pulse) state_nx = IDLE;
               else if (isdead)   state_nx = DEAD;
      DEAD:    if (restart_pulse) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  logic [2:0] spd_dec;
  logic [1:0] dif_dec;
  always_comb begin
    spd_dec = 3'd2;
    if      (sync[5]) spd_dec = 3'd6;
    else if (sync[4]) spd_dec = 3'd5;
    else if (sync[3]) spd_dec = 3'd4;
    else if (sync[2]) spd_dec = 3'd3;
    dif_dec = 2'd0;
    if      (sync[9]) dif_dec = 2'd3;
    else if (sync[8]) dif_dec = 2'd2;
    else if (sync[7]) dif_dec = 2'd1;
  end

  // Settings are frozen once the game leaves IDLE.
  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      start      <= 1'b0;
      speed      <= 3'd2;
      difficulty <= 2'd0;
    end else begin
      start <= (state_nx == RUN);
      if (state == IDLE) begin
        speed      <= spd_dec;
        difficulty <= dif_dec;
      end
    end
  end
endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=16.
module tb_input_conditioner;
  localparam int DB = 4;
  localparam int RP = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       jump_btn, restart_btn, isdead;
  logic [3:0] speed_in, difficulty_in;
  logic       jump, jump_pulse, start, restart_pulse;
  logic [2:0] speed;
  logic [1:0] difficulty;

  always #5 clk = ~clk;

  input_conditioner #(.DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(RP)) dut (
    .CLK100MHZ    (clk),
    .reset_n      (rst_n),
    .jump_btn     (jump_btn),
    .restart_btn  (restart_btn),
    .isdead       (isdead),
    .speed_in     (speed_in),
    .difficulty_in(difficulty_in),
    .jump         (jump),
    .jump_pulse   (jump_pulse),
    .start        (start),
    .restart_pulse(restart_pulse),
    .speed        (speed),
    .difficulty   (difficulty)
  );

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int jp_cnt = 0;
  int rp_cnt = 0;
  int jp_times[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (jump_pulse) begin
      jp_cnt <= jp_cnt + 1;
      jp_times.push_back(cyc);
    end
    if (restart_pulse) rp_cnt <= rp_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, required %0d", nm, act, exp);
  endtask

  // which: 0 = jump, 1 = restart; hold n cycles then let the release debounce out
  task automatic press(input int which, input int n);
    if (which == 0) jump_btn = 1'b1; else restart_btn = 1'b1;
    tick(n);
    if (which == 0) jump_btn = 1'b0; else restart_btn = 1'b0;
    tick(8);
  endtask

  typedef struct {
    logic [3:0] spd_in;
    logic [3:0] dif_in;
    int         exp_spd;
    int         exp_dif;
  } set_vec_t;

  set_vec_t vecs[7];
  int jb, rb, n, base;

  initial begin
    vecs[0] = '{4'b0000, 4'b0000, 2, 0};
    vecs[1] = '{4'b0001, 4'b0001, 3, 0};
    vecs[2] = '{4'b0010, 4'b0010, 4, 1};
    vecs[3] = '{4'b1000, 4'b0100, 6, 2};
    vecs[4] = '{4'b1111, 4'b0110, 6, 2};
    vecs[5] = '{4'b0011, 4'b0011, 4, 1};
    vecs[6] = '{4'b0110, 4'b1001, 5, 3};

    // reset with every input high
    rst_n = 1'b1; jump_btn = 1'b1; restart_btn = 1'b1; isdead = 1'b1;
    speed_in = 4'hF; difficulty_in = 4'hF;
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_jump", jump, 0);
    chk("rst_jump_pulse", jump_pulse, 0);
    chk("rst_start", start, 0);
    chk("rst_restart_pulse", restart_pulse, 0);
    chk("rst_speed", speed, 2);
    chk("rst_difficulty", difficulty, 0);
    tick(3);
    chk("rst_hold_start", start, 0);
    chk("rst_hold_speed", speed, 2);

    // release with jump held: debounced after DB+2 edges, one pulse, RUN
    jb = jp_cnt; rb = rp_cnt;
    restart_btn = 1'b0; isdead = 1'b0;
    rst_n = 1'b1;
    tick(5);
    chk("rel_jump_early", jump, 0);
    tick();
    chk("rel_jump_level", jump, 1);
    chk("rel_jump_pulse", jump_pulse, 1);
    chk("rel_start_before", start, 0);
    tick();
    chk("rel_pulse_width", jump_pulse, 0);
    chk("rel_start_run", start, 1);
    jump_btn = 1'b0;
    tick(8);
    chk("rel_jp_count", jp_cnt - jb, 1);
    chk("rel_jump_released", jump, 0);

    // restart from RUN back to IDLE
    press(1, 10);
    chk("rs_rp_count", rp_cnt - rb, 1);
    chk("rs_start_idle", start, 0);

    // 3-cycle glitch is filtered
    jb = jp_cnt;
    press(0, 3);
    chk("gl_jp_count", jp_cnt - jb, 0);
    chk("gl_start", start, 0);
    chk("gl_jump", jump, 0);

    // settings decode in IDLE
    for (int i = 0; i < 7; i++) begin
      speed_in = vecs[i].spd_in;
      difficulty_in = vecs[i].dif_in;
      tick(3);
      chk($sformatf("set_speed[%0d]", i), speed, vecs[i].exp_spd);
      chk($sformatf("set_diff[%0d]", i), difficulty, vecs[i].exp_dif);
    end

    // 10-cycle press: one pulse, start a cycle later
    jb = jp_cnt;
    jump_btn = 1'b1;
    tick(5);
    chk("p10_pulse_early", jump_pulse, 0);
    tick();
    chk("p10_pulse", jump_pulse, 1);
    chk("p10_start_before", start, 0);
    tick();
    chk("p10_pulse_width", jump_pulse, 0);
    chk("p10_start", start, 1);
    tick(3);
    jump_btn = 1'b0;
    tick(8);
    chk("p10_jp_count", jp_cnt - jb, 1);

    // switches frozen in RUN
    speed_in = 4'b1111; difficulty_in = 4'b0000;
    tick(5);
    chk("run_speed_held", speed, 5);
    chk("run_diff_held", difficulty, 3);

    // held jump in RUN
    base = jp_times.size();
    jump_btn = 1'b1;
    tick(50);
    jump_btn = 1'b0;
    tick(10);
    n = jp_times.size() - base;
`ifdef JUMP_REPEAT_EN
    chk("rpt_count", n, 4);
`else
    chk("rpt_count", n, 1);
`endif
    if (n >= 2) chk("rpt_gap_first", jp_times[base+1] - jp_times[base], RP);
    if (n >= 3) chk("rpt_gap_last", jp_times[base+n-1] - jp_times[base+n-2], RP);
    chk("rpt_start", start, 1);

    // death: start falls, jump ignored, restart returns to IDLE
    isdead = 1'b1;
    tick();
    chk("dead_start", start, 0);
    isdead = 1'b0;
    jb = jp_cnt;
    press(0, 10);
    chk("dead_jp_count", jp_cnt - jb, 0);
    chk("dead_start_hold", start, 0);
    rb = rp_cnt;
    press(1, 10);
    chk("dead_rp_count", rp_cnt - rb, 1);
    chk("idle_speed_resample", speed, 6);
    chk("idle_diff_resample", difficulty, 0);
    jb = jp_cnt;
    press(0, 10);
    chk("idle_jp_count", jp_cnt - jb, 1);
    chk("idle_to_run", start, 1);

    // restart and isdead in the same RUN cycle: IDLE wins
    restart_btn = 1'b1;
    tick(6);
    chk("col_rp", restart_pulse, 1);
    isdead = 1'b1;
    tick();
    chk("col_rp_width", restart_pulse, 0);
    chk("col_start", start, 0);
    isdead = 1'b0;
    restart_btn = 1'b0;
    tick(8);
    jb = jp_cnt;
    press(0, 10);
    chk("col_jp_count", jp_cnt - jb, 1);
    chk("col_start_run", start, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
